// File: rtl/dffram_wb_ctrl.sv
// Wishbone classic slave in front of a single DFFRAM macro.
// Every RAM control is registered. The RAM's one-cycle read latency is hidden
// behind a fixed four-state access sequence, so a request is accepted, performed,
// acknowledged and retired in four cycles. An optional zero-fill runs after reset.
module dffram_wb_ctrl #(
    parameter int COLS           = 1,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int A_WIDTH       = 8 + $clog2(COLS)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [3:0]         wb_sel_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               ram_en,
    output logic [3:0]         ram_we,
    output logic [A_WIDTH-1:0] ram_a,
    output logic [31:0]        ram_di,
    input  logic [31:0]        ram_do,
    output logic               init_done
);

    // One extra counter bit lets the fill counter reach N, which marks
    // "every word has been driven" without a separate flag.
    localparam logic [A_WIDTH:0] N_WORDS = (A_WIDTH + 1)'(256 * COLS);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_ACCESS,
        S_RESP,
        S_ACK
    } state_t;

    state_t             state_reg;
    logic [A_WIDTH:0]   fill_cnt_reg;
    logic               we_reg;

    // Byte-offset bits and address bits above the array are intentionally
    // ignored, so the array aliases across the decoded window.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[31:A_WIDTH+2], wb_adr_i[1:0]};

    // Controller FSM: zero-fill, then accept / perform / respond / retire.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            init_done    <= ~CLEAR_ON_RESET;
            fill_cnt_reg <= '0;
            we_reg       <= 1'b0;
            wb_ack_o     <= 1'b0;
            wb_dat_o     <= '0;
            ram_en       <= 1'b0;
            ram_we       <= 4'h0;
            ram_a        <= '0;
            ram_di       <= '0;
        end else begin
            case (state_reg)
                S_CLEAR: begin
                    if (fill_cnt_reg == N_WORDS) begin
                        ram_en    <= 1'b0;
                        ram_we    <= 4'h0;
                        init_done <= 1'b1;
                        state_reg <= S_IDLE;
                    end else begin
                        ram_en       <= 1'b1;
                        ram_we       <= 4'hF;
                        ram_di       <= '0;
                        ram_a        <= fill_cnt_reg[A_WIDTH-1:0];
                        fill_cnt_reg <= fill_cnt_reg + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        ram_en    <= 1'b1;
                        ram_a     <= wb_adr_i[A_WIDTH+1:2];
                        ram_di    <= wb_dat_i;
                        ram_we    <= wb_we_i ? wb_sel_i : 4'h0;
                        we_reg    <= wb_we_i;
                        state_reg <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // The RAM samples EN/WE on this edge; drop them so it fires once.
                    ram_en    <= 1'b0;
                    ram_we    <= 4'h0;
                    state_reg <= S_RESP;
                end
                S_RESP: begin
                    // A master that dropped cyc gets no ack; an issued write still lands.
                    if (wb_cyc_i) begin
                        wb_ack_o  <= 1'b1;
                        wb_dat_o  <= we_reg ? 32'h0 : ram_do;
                        state_reg <= S_ACK;
                    end else begin
                        wb_ack_o  <= 1'b0;
                        wb_dat_o  <= '0;
                        state_reg <= S_IDLE;
                    end
                end
                S_ACK: begin
                    // The strobe still visible here belongs to the retired request.
                    wb_ack_o  <= 1'b0;
                    wb_dat_o  <= '0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule
